// File: rtl/sod_draw_pkg.sv
// rtl/sod_draw_pkg.sv - shared colors, command and state types for the sudoku draw engine
package sod_draw_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int X_W      = $clog2(SCREEN_W);
   localparam int Y_W      = $clog2(SCREEN_H);

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b001;

   typedef enum logic [2:0] {
      NONE, BOARD, CHAR, CHAR_REP, TRK, TRK_REP, WRONG, WIN
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE, LOAD, ERASE, SWEEP, GAP, DONE
   } state_t;

endpackage

// File: rtl/sod_glyph_rom.sv
// rtl/sod_glyph_rom.sv - 8x8 bitmaps of the four sudoku characters '1'..'4', MSB is leftmost
module sod_glyph_rom (
   input  logic [1:0] char_sel_i,
   input  logic [2:0] gx_i,
   input  logic [2:0] gy_i,
   output logic       bit_o
);
   logic [7:0] row_bits;

   always_comb begin
      row_bits = 8'h00;
      case ({char_sel_i, gy_i})
         5'd0:  row_bits = 8'h18;  5'd1:  row_bits = 8'h38;
         5'd2:  row_bits = 8'h18;  5'd3:  row_bits = 8'h18;
         5'd4:  row_bits = 8'h18;  5'd5:  row_bits = 8'h18;
         5'd6:  row_bits = 8'h7E;
         5'd8:  row_bits = 8'h3C;  5'd9:  row_bits = 8'h66;
         5'd10: row_bits = 8'h06;  5'd11: row_bits = 8'h0C;
         5'd12: row_bits = 8'h30;  5'd13: row_bits = 8'h60;
         5'd14: row_bits = 8'h7E;
         5'd16: row_bits = 8'h3C;  5'd17: row_bits = 8'h66;
         5'd18: row_bits = 8'h06;  5'd19: row_bits = 8'h1C;
         5'd20: row_bits = 8'h06;  5'd21: row_bits = 8'h66;
         5'd22: row_bits = 8'h3C;
         5'd24: row_bits = 8'h0C;  5'd25: row_bits = 8'h1C;
         5'd26: row_bits = 8'h2C;  5'd27: row_bits = 8'h4C;
         5'd28: row_bits = 8'h7E;  5'd29: row_bits = 8'h0C;
         5'd30: row_bits = 8'h0C;
         default: row_bits = 8'h00;
      endcase
      bit_o = row_bits[3'd7 - gx_i];
   end
endmodule

// File: rtl/sod_draw_engine.sv
// rtl/sod_draw_engine.sv - turns edge-detected draw commands into one-pixel-per-cycle rectangle sweeps
module sod_draw_engine
   import sod_draw_pkg::*;
#(
   parameter int X0        = 256,
   parameter int Y0        = 176,
   parameter int CELL_LOG2 = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           drawBoard,
   input  logic           drawChar,
   input  logic           drawCharRepeat,
   input  logic           drawTracker,
   input  logic           drawTrackerRepeat,
   input  logic           drawWrong,
   input  logic           drawWin,
   input  logic [1:0]     row,
   input  logic [1:0]     col,
   input  logic [1:0]     charSel,
   output logic [X_W-1:0] pixX,
   output logic [Y_W-1:0] pixY,
   output logic [2:0]     pixColor,
   output logic           pixWe,
   output logic           busy,
   output logic           drawDone
);
   localparam int CELL = 1 << CELL_LOG2;
   localparam logic [X_W-1:0] SPAN_BOARD = X_W'(4 * CELL);
   localparam logic [X_W-1:0] SPAN_INT   = X_W'(CELL - 2);
   localparam logic [X_W-1:0] SPAN_TRK   = X_W'(CELL);

   state_t state_q, state_d;
   cmd_t   new_cmd, cur_cmd_q, pend_cmd_q;
   logic [6:0] lines, prev_q, rise;
   logic       edge_any, pend_valid_q, trk_valid_q, sweeping, last_px;
   logic [1:0] cur_row_q, cur_col_q, cur_chr_q, pend_row_q, pend_col_q, pend_chr_q;
   logic [1:0] trk_row_q, trk_col_q, ld_row, ld_col;
   logic [X_W-1:0] rx0_q, span_q, ox_q, oy_q, ld_x, ld_span, gx_full, gy_full;
   logic [Y_W-1:0] ry0_q, ld_y;
   logic [X_W-1:0] pix_x_q;
   logic [Y_W-1:0] pix_y_q;
   logic [2:0]     pix_color_q, pix_color_d;
   logic           pix_we_q, pix_we_d, done_q, busy_q, grid, ring, glyph_raw, glyph;

   // Bit order is the simultaneous-edge priority, highest first.
   assign lines    = {drawWin, drawBoard, drawWrong, drawCharRepeat, drawChar,
                      drawTrackerRepeat, drawTracker};
   assign rise     = lines & ~prev_q;
   assign edge_any = (rise != 7'd0);

   always_comb begin
      new_cmd = NONE;
      if      (rise[6]) new_cmd = WIN;
      else if (rise[5]) new_cmd = BOARD;
      else if (rise[4]) new_cmd = WRONG;
      else if (rise[3]) new_cmd = CHAR_REP;
      else if (rise[2]) new_cmd = CHAR;
      else if (rise[1]) new_cmd = TRK_REP;
      else if (rise[0]) new_cmd = TRK;
   end

   assign sweeping = (state_q == SWEEP) || (state_q == ERASE);
   assign last_px  = (ox_q == span_q) && (oy_q == span_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (edge_any) state_d = LOAD;
         LOAD:  state_d = (cur_cmd_q == TRK_REP && trk_valid_q) ? ERASE : SWEEP;
         ERASE: if (last_px) state_d = GAP;
         GAP:   state_d = SWEEP;
         SWEEP: if (last_px) state_d = DONE;
         DONE:  state_d = (edge_any || pend_valid_q) ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Rectangle for the next phase: the erase ring uses the stored tracker cell.
   always_comb begin
      ld_row  = (state_q == LOAD && cur_cmd_q == TRK_REP && trk_valid_q) ? trk_row_q : cur_row_q;
      ld_col  = (state_q == LOAD && cur_cmd_q == TRK_REP && trk_valid_q) ? trk_col_q : cur_col_q;
      ld_x    = X_W'(X0) + (X_W'(ld_col) << CELL_LOG2);
      ld_y    = Y_W'(Y0) + (Y_W'(ld_row) << CELL_LOG2);
      ld_span = SPAN_TRK;
      case (cur_cmd_q)
         BOARD, WIN: begin
            ld_x = X_W'(X0);  ld_y = Y_W'(Y0);  ld_span = SPAN_BOARD;
         end
         CHAR, CHAR_REP, WRONG: begin
            ld_x = ld_x + 1'b1;  ld_y = ld_y + 1'b1;  ld_span = SPAN_INT;
         end
         default: ;
      endcase
   end

   assign gx_full = ox_q >> (CELL_LOG2 - 3);
   assign gy_full = oy_q >> (CELL_LOG2 - 3);

   sod_glyph_rom u_glyph (
      .char_sel_i (cur_chr_q),
      .gx_i       (gx_full[2:0]),
      .gy_i       (gy_full[2:0]),
      .bit_o      (glyph_raw)
   );

   always_comb begin
      grid  = (ox_q[CELL_LOG2-1:0] == '0) || (oy_q[CELL_LOG2-1:0] == '0);
      ring  = (ox_q == '0) || (ox_q == span_q) || (oy_q == '0) || (oy_q == span_q);
      glyph = glyph_raw && (gx_full < X_W'(8)) && (gy_full < X_W'(8));
      pix_we_d    = 1'b0;
      pix_color_d = BLACK;
      if (state_q == ERASE) begin
         pix_we_d = ring;
      end else begin
         case (cur_cmd_q)
            BOARD:       begin pix_we_d = 1'b1;  pix_color_d = grid ? BLACK : WHITE; end
            WIN:         begin pix_we_d = grid;  pix_color_d = GREEN; end
            CHAR:        begin pix_we_d = glyph; pix_color_d = BLACK; end
            CHAR_REP:    begin pix_we_d = 1'b1;  pix_color_d = glyph ? BLACK : WHITE; end
            WRONG:       begin pix_we_d = 1'b1;  pix_color_d = RED; end
            TRK, TRK_REP: begin pix_we_d = ring; pix_color_d = BLUE; end
            default:     ;
         endcase
      end
      if (!sweeping) pix_we_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;  pend_valid_q <= 1'b0;  trk_valid_q <= 1'b0;
         cur_cmd_q <= NONE;  cur_row_q <= '0;  cur_col_q <= '0;  cur_chr_q <= '0;
         pend_cmd_q <= NONE; pend_row_q <= '0; pend_col_q <= '0; pend_chr_q <= '0;
         trk_row_q <= '0;  trk_col_q <= '0;
         rx0_q <= '0;  ry0_q <= '0;  span_q <= '0;  ox_q <= '0;  oy_q <= '0;
         pix_x_q <= '0;  pix_y_q <= '0;  pix_color_q <= BLACK;  pix_we_q <= 1'b0;
         done_q <= 1'b0;  busy_q <= 1'b0;
      end else begin
         prev_q <= lines;
         if (state_q == IDLE || state_q == DONE) begin
            if (edge_any) begin
               cur_cmd_q <= new_cmd;  cur_row_q <= row;  cur_col_q <= col;  cur_chr_q <= charSel;
               pend_valid_q <= 1'b0;
            end else if (state_q == DONE && pend_valid_q) begin
               cur_cmd_q <= pend_cmd_q;  cur_row_q <= pend_row_q;
               cur_col_q <= pend_col_q;  cur_chr_q <= pend_chr_q;
               pend_valid_q <= 1'b0;
            end
         end else if (edge_any) begin
            pend_cmd_q <= new_cmd;  pend_row_q <= row;  pend_col_q <= col;  pend_chr_q <= charSel;
            pend_valid_q <= 1'b1;
         end

         if (state_q == LOAD || state_q == GAP) begin
            rx0_q <= ld_x;  ry0_q <= ld_y;  span_q <= ld_span;  ox_q <= '0;  oy_q <= '0;
         end else if (sweeping) begin
            if (ox_q == span_q) begin
               ox_q <= '0;
               oy_q <= oy_q + 1'b1;
            end else begin
               ox_q <= ox_q + 1'b1;
            end
         end

         if (state_q == LOAD && cur_cmd_q == BOARD) trk_valid_q <= 1'b0;
         if ((state_q == LOAD || state_q == GAP) && state_d == SWEEP &&
             (cur_cmd_q == TRK || cur_cmd_q == TRK_REP)) begin
            trk_row_q <= cur_row_q;  trk_col_q <= cur_col_q;  trk_valid_q <= 1'b1;
         end

         pix_we_q <= pix_we_d;
         if (sweeping) begin
            pix_x_q     <= rx0_q + ox_q;
            pix_y_q     <= ry0_q + oy_q[Y_W-1:0];
            pix_color_q <= pix_color_d;
         end
         done_q <= (state_q == DONE);
         busy_q <= (state_d != IDLE);
      end
   end

   assign pixX     = pix_x_q;
   assign pixY     = pix_y_q;
   assign pixColor = pix_color_q;
   assign pixWe    = pix_we_q;
   assign busy     = busy_q;
   assign drawDone = done_q;
endmodule

// File: tb/tb_sod_draw_engine.sv
// tb/tb_sod_draw_engine.sv - directed bench with a pixel-list model of every draw command
module tb_sod_draw_engine;
   localparam int X0 = 256;
   localparam int Y0 = 176;
   localparam int C  = 32;
   localparam int M_BOARD = 0, M_CHAR = 1, M_CHAR_REP = 2, M_TRK = 3, M_TRK_REP = 4,
                  M_WRONG = 5, M_WIN = 6;

   logic clk = 1'b0;
   logic reset;
   logic [6:0] lines;
   logic [1:0] row, col, charSel;
   logic [9:0] pixX;
   logic [8:0] pixY;
   logic [2:0] pixColor;
   logic       pixWe, busy, drawDone;

   sod_draw_engine dut (
      .clk               (clk),
      .reset             (reset),
      .drawBoard         (lines[0]),
      .drawChar          (lines[1]),
      .drawCharRepeat    (lines[2]),
      .drawTracker       (lines[3]),
      .drawTrackerRepeat (lines[4]),
      .drawWrong         (lines[5]),
      .drawWin           (lines[6]),
      .row               (row),
      .col               (col),
      .charSel           (charSel),
      .pixX              (pixX),
      .pixY              (pixY),
      .pixColor          (pixColor),
      .pixWe             (pixWe),
      .busy              (busy),
      .drawDone          (drawDone)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] glyph_tab [0:31] = '{
      8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
      8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
      8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
      8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C, 8'h00};

   int exp_x[$], exp_y[$], exp_c[$];
   int checks = 0, errors = 0;
   int m_trk_valid = 0, m_trk_r = 0, m_trk_c = 0;

   int wcount, done_cnt, first_wcyc, first_x, first_y, first_c;
   int minx, maxx, miny, maxy, cnt_black, cnt_blue, last_black_cyc, first_blue_cyc;
   int black_maxx, blue_minx, probe_x, probe_y, probe_c;
   int ex, ey, ec;

   function automatic int glyph_on(int ch, int gx, int gy);
      logic [7:0] r;
      r = glyph_tab[ch * 8 + gy];
      return int'(r[7 - gx]);
   endfunction

   task automatic push(int x, int y, int c);
      exp_x.push_back(x); exp_y.push_back(y); exp_c.push_back(c);
   endtask

   task automatic push_ring(int rx, int ry, int color);
      for (int y = ry; y <= ry + C; y++)
         for (int x = rx; x <= rx + C; x++)
            if (x == rx || x == rx + C || y == ry || y == ry + C) push(x, y, color);
   endtask

   // Expected write list for one command, straight from the drawing rules.
   task automatic model_cmd(int cmd, int r, int c, int ch);
      int cx, cy, grid, g;
      cx = X0 + c * C;
      cy = Y0 + r * C;
      case (cmd)
         M_BOARD, M_WIN: begin
            for (int y = Y0; y <= Y0 + 4 * C; y++)
               for (int x = X0; x <= X0 + 4 * C; x++) begin
                  grid = ((x - X0) % C == 0) || ((y - Y0) % C == 0);
                  if (cmd == M_BOARD) push(x, y, grid ? 0 : 7);
                  else if (grid != 0) push(x, y, 2);
               end
            if (cmd == M_BOARD) m_trk_valid = 0;
         end
         M_CHAR, M_CHAR_REP, M_WRONG: begin
            for (int y = cy + 1; y <= cy + C - 1; y++)
               for (int x = cx + 1; x <= cx + C - 1; x++) begin
                  g = glyph_on(ch, (x - cx - 1) / (C / 8), (y - cy - 1) / (C / 8));
                  if (cmd == M_WRONG) push(x, y, 4);
                  else if (cmd == M_CHAR_REP) push(x, y, g != 0 ? 0 : 7);
                  else if (g != 0) push(x, y, 0);
               end
         end
         default: begin
            if (cmd == M_TRK_REP && m_trk_valid != 0)
               push_ring(X0 + m_trk_c * C, Y0 + m_trk_r * C, 0);
            push_ring(cx, cy, 1);
            m_trk_valid = 1; m_trk_r = r; m_trk_c = c;
         end
      endcase
   endtask

   task automatic clear_stats();
      wcount = 0; done_cnt = 0; first_wcyc = -1; first_x = -1; first_y = -1; first_c = -1;
      minx = 9999; maxx = -1; miny = 9999; maxy = -1; cnt_black = 0; cnt_blue = 0;
      last_black_cyc = -1; first_blue_cyc = -1; black_maxx = -1; blue_minx = 9999;
      probe_c = -1;
   endtask

   always @(negedge clk) begin
      if (drawDone === 1'b1) done_cnt++;
      if (pixWe === 1'b1) begin
         wcount++;
         if (first_wcyc < 0) begin
            first_wcyc = cyc; first_x = int'(pixX); first_y = int'(pixY); first_c = int'(pixColor);
         end
         if (int'(pixX) < minx) minx = int'(pixX);
         if (int'(pixX) > maxx) maxx = int'(pixX);
         if (int'(pixY) < miny) miny = int'(pixY);
         if (int'(pixY) > maxy) maxy = int'(pixY);
         if (pixColor == 3'b000) begin
            cnt_black++; last_black_cyc = cyc;
            if (int'(pixX) > black_maxx) black_maxx = int'(pixX);
         end
         if (pixColor == 3'b001) begin
            cnt_blue++;
            if (first_blue_cyc < 0) first_blue_cyc = cyc;
            if (int'(pixX) < blue_minx) blue_minx = int'(pixX);
         end
         if (int'(pixX) == probe_x && int'(pixY) == probe_y) probe_c = int'(pixColor);
         checks++;
         if (exp_x.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got (%0d,%0d) color %0d want no write",
                     pixX, pixY, pixColor);
         end else begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            if (int'(pixX) != ex || int'(pixY) != ey || int'(pixColor) != ec) begin
               errors++;
               $display("FAIL pixel_write got (%0d,%0d) color %0d want (%0d,%0d) color %0d",
                        pixX, pixY, pixColor, ex, ey, ec);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(string nm, int act, int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, want);
      end
   endtask

   task automatic wait_done(int limit);
      int n = 0;
      while (drawDone !== 1'b1 && n < limit) begin
         tick(); n++;
      end
      chk("draw_done_seen", int'(drawDone === 1'b1), 1);
   endtask

   task automatic fire(int idx, int r, int c, int ch);
      row = 2'(r); col = 2'(c); charSel = 2'(ch);
      lines[idx] = 1'b1;
      repeat (3) tick();
      lines[idx] = 1'b0;
   endtask

   int edge_cyc, w_saved;

   initial begin
      probe_x = 257; probe_y = 177;
      clear_stats();
      reset = 1'b1; lines = 7'd0; lines[0] = 1'b1; row = 2'd0; col = 2'd0; charSel = 2'd0;
      tick();
      chk("rst_pixWe", int'(pixWe), 0);
      chk("rst_pixX", int'(pixX), 0);
      chk("rst_pixY", int'(pixY), 0);
      chk("rst_pixColor", int'(pixColor), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drawDone", int'(drawDone), 0);
      tick();

      // Board held high through reset: edge on the first cycle after release.
      model_cmd(M_BOARD, 0, 0, 0);
      clear_stats();
      edge_cyc = cyc + 1;
      reset = 1'b0;
      wait_done(17000);
      repeat (20) tick();
      lines[0] = 1'b0;
      tick();
      chk("board_first_latency", first_wcyc - edge_cyc, 2);
      chk("board_first_x", first_x, 256);
      chk("board_first_y", first_y, 176);
      chk("board_first_color", first_c, 0);
      chk("board_probe_257_177", probe_c, 7);
      chk("board_writes", wcount, 16641);
      chk("board_done_pulses", done_cnt, 1);
      chk("board_queue_left", exp_x.size(), 0);
      chk("board_busy_after", int'(busy), 0);

      clear_stats();
      model_cmd(M_WRONG, 1, 2, 0);
      row = 2'd1; col = 2'd2; lines[5] = 1'b1;
      tick();
      chk("wrong_busy_load", int'(busy), 1);
      tick(); tick();
      lines[5] = 1'b0;
      wait_done(2000);
      repeat (3) tick();
      chk("wrong_writes", wcount, 961);
      chk("wrong_minx", minx, 321);
      chk("wrong_maxx", maxx, 351);
      chk("wrong_miny", miny, 209);
      chk("wrong_maxy", maxy, 239);
      chk("wrong_done_pulses", done_cnt, 1);
      chk("wrong_queue_left", exp_x.size(), 0);

      clear_stats();
      model_cmd(M_CHAR, 0, 0, 2);
      fire(1, 0, 0, 2);
      wait_done(2000);
      repeat (3) tick();
      chk("char_writes", wcount, 368);
      chk("char_queue_left", exp_x.size(), 0);

      clear_stats();
      model_cmd(M_CHAR_REP, 0, 0, 2);
      fire(2, 0, 0, 2);
      wait_done(2000);
      repeat (3) tick();
      chk("charrep_writes", wcount, 961);
      chk("charrep_queue_left", exp_x.size(), 0);

      clear_stats();
      model_cmd(M_TRK, 0, 0, 0);
      fire(3, 0, 0, 0);
      wait_done(2000);
      repeat (3) tick();
      chk("trk_blue", cnt_blue, 128);

      clear_stats();
      model_cmd(M_TRK_REP, 0, 1, 0);
      fire(4, 0, 1, 0);
      wait_done(4000);
      repeat (3) tick();
      chk("trkrep_black", cnt_black, 128);
      chk("trkrep_blue", cnt_blue, 128);
      chk("trkrep_black_maxx", black_maxx, 288);
      chk("trkrep_blue_minx", blue_minx, 288);
      chk("trkrep_gap", first_blue_cyc - last_black_cyc, 2);
      chk("trkrep_queue_left", exp_x.size(), 0);

      clear_stats();
      model_cmd(M_BOARD, 0, 0, 0);
      fire(0, 0, 0, 0);
      wait_done(17000);
      repeat (3) tick();
      clear_stats();
      model_cmd(M_TRK_REP, 2, 3, 0);
      fire(4, 2, 3, 0);
      wait_done(2000);
      repeat (3) tick();
      chk("noerase_black", cnt_black, 0);
      chk("noerase_blue", cnt_blue, 128);
      chk("noerase_queue_left", exp_x.size(), 0);

      // Win arrives mid-Board: held pending, served after Board, then reset cuts it.
      clear_stats();
      model_cmd(M_BOARD, 0, 0, 0);
      model_cmd(M_WIN, 0, 0, 0);
      lines[0] = 1'b1;
      repeat (100) tick();
      lines[0] = 1'b0;
      lines[6] = 1'b1;
      wait_done(17000);
      chk("pending_board_writes", wcount, 16641);
      repeat (300) tick();
      chk("pending_done_pulses", done_cnt, 1);
      chk("win_busy", int'(busy), 1);
      chk("win_started", int'(wcount > 16641), 1);
      reset = 1'b1; lines = 7'd0;
      tick();
      exp_x.delete(); exp_y.delete(); exp_c.delete();
      chk("midreset_pixWe", int'(pixWe), 0);
      chk("midreset_busy", int'(busy), 0);
      w_saved = wcount;
      tick();
      reset = 1'b0;
      repeat (50) tick();
      chk("midreset_no_writes", wcount, w_saved);
      chk("midreset_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
